// File: rtl/maxpool_seq.sv
// -----------------------------------------------------------------------------
// maxpool_seq
//
// Sequential max-pooling stage for the garbled ReLU pipeline. Each valid
// cycle it reconstructs one value from the evaluator share and the garbler
// mask (v = r_in + e_input mod 2^N). It keeps an unsigned running maximum over
// a window of K valid inputs. When the window completes, it emits the maximum
// remasked with the garbler's fresh output mask r_out, so the evaluator only
// ever sees masked data.
//
// Optional feature macro: MAXPOOL_ARGMAX_EN
//   When defined, adds output o_idx, which is the in-window position of the
//   selected maximum. Ties resolve to the lowest index.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   in_valid  qualifies g_input / e_input this cycle
//   g_input   garbler masks {r_in, r_out}, each N bits
//   e_input   evaluator share relu(x) - r_in
//   o         window max + r_out (mod 2^N), held until the next window
//   o_valid   one-cycle pulse when o carries a new result
//   o_idx     (MAXPOOL_ARGMAX_EN only) position of the max inside the window
// -----------------------------------------------------------------------------
module maxpool_seq #(
  parameter  int N  = 32,
  parameter  int K  = 4,
  localparam int CW = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [2*N-1:0] g_input,
  input  logic [N-1:0]   e_input,
  output logic [N-1:0]   o,
  output logic           o_valid
`ifdef MAXPOOL_ARGMAX_EN
  ,
  output logic [CW-1:0]  o_idx
`endif
);

  logic [CW-1:0] cnt_r;
  logic [N-1:0]  max_r;

  logic [N-1:0]  r_in_s;
  logic [N-1:0]  r_out_s;
  logic [N-1:0]  v_s;
  logic          win_start_s;
  logic          win_last_s;
  logic          greater_s;
  logic [N-1:0]  max_next_s;

`ifdef MAXPOOL_ARGMAX_EN
  logic [CW-1:0] idx_r;
  logic [CW-1:0] idx_next_s;
`endif

  // Reconstruct the plaintext value and compute the updated window maximum.
  always_comb begin
    r_in_s      = g_input[2*N-1:N];
    r_out_s     = g_input[N-1:0];
    v_s         = r_in_s + e_input;
    win_start_s = (cnt_r == CW'(0));
    win_last_s  = (cnt_r == CW'(K-1));
    // Strict compare keeps the earlier element on a tie.
    greater_s   = (v_s > max_r);
    // At window start the previous window's max is discarded outright.
    max_next_s  = (win_start_s || greater_s) ? v_s : max_r;
`ifdef MAXPOOL_ARGMAX_EN
    idx_next_s  = win_start_s ? CW'(0) : (greater_s ? cnt_r : idx_r);
`endif
  end

  // Window counter, running maximum and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= CW'(0);
      max_r   <= N'(0);
      o       <= N'(0);
      o_valid <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
      idx_r   <= CW'(0);
      o_idx   <= CW'(0);
`endif
    end else if (in_valid) begin
      max_r <= max_next_s;
`ifdef MAXPOOL_ARGMAX_EN
      idx_r <= idx_next_s;
`endif
      if (win_last_s) begin
        // Only the last element's r_out masks the result.
        o       <= max_next_s + r_out_s;
        o_valid <= 1'b1;
        cnt_r   <= CW'(0);
`ifdef MAXPOOL_ARGMAX_EN
        o_idx   <= idx_next_s;
`endif
      end else begin
        o_valid <= 1'b0;
        cnt_r   <= cnt_r + CW'(1);
      end
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_seq.sv
// -----------------------------------------------------------------------------
// tb_maxpool_seq
//
// Self-checking bench for maxpool_seq (N=32, K=4). Inputs are driven on the
// falling edge, and outputs are observed on the falling edge. Expected results
// come from a window-level reference model that takes the maximum of a list of
// values (the lowest index wins ties) and adds the last r_out.
// -----------------------------------------------------------------------------
module tb_maxpool_seq;

  localparam int N = 32;
  localparam int K = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [2*N-1:0] g_input;
  logic [N-1:0]   e_input;
  logic [N-1:0]   o;
  logic           o_valid;
`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0]     o_idx;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  maxpool_seq #(.N(N), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .g_input  (g_input),
    .e_input  (e_input),
    .o        (o),
    .o_valid  (o_valid)
`ifdef MAXPOOL_ARGMAX_EN
    ,
    .o_idx    (o_idx)
`endif
  );

  // Reference: max over the window (lowest index on ties), remasked.
  function automatic void ref_pool(input logic [31:0] vals[4], input logic [31:0] rout,
                                   output logic [31:0] eo, output int eidx);
    eidx = 0;
    for (int i = 1; i < 4; i++)
      if (vals[i] > vals[eidx]) eidx = i;
    eo = vals[eidx] + rout;
  endfunction

  // Drive one valid element whose reconstructed value is val.
  task automatic send(input logic [31:0] val, input logic [31:0] rin, input logic [31:0] rout);
    @(negedge clk);
    in_valid = 1'b1;
    g_input  = {rin, rout};
    e_input  = val - rin;
  endtask

  // Drive n idle cycles carrying junk data.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      g_input  = {$urandom, $urandom};
      e_input  = $urandom;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; g_input = '0; e_input = '0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (o !== 32'd0) $display("FAIL reset_o actual=%h required=%h", o, 32'd0); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid actual=%b required=0", o_valid); else n_pass++;
    n_checks++; if (dut.cnt_r !== 2'd0) $display("FAIL reset_cnt actual=%0d required=0", dut.cnt_r); else n_pass++;
    n_checks++; if (dut.max_r !== 32'd0) $display("FAIL reset_max actual=%h required=0", dut.max_r); else n_pass++;
`ifdef MAXPOOL_ARGMAX_EN
    n_checks++; if (o_idx !== 2'd0) $display("FAIL reset_o_idx actual=%0d required=0", o_idx); else n_pass++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic;
    send(32'd5, 32'd0, 32'd0); send(32'd9, 32'd0, 32'd0);
    send(32'd3, 32'd0, 32'd0); send(32'd7, 32'd0, 32'd0);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL basic_early actual=%b required=0", o_valid); else n_pass++;
    idle(1);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL basic_valid actual=%b required=1", o_valid); else n_pass++;
    n_checks++; if (o !== 32'd9) $display("FAIL basic_o actual=%h required=%h", o, 32'd9); else n_pass++;
`ifdef MAXPOOL_ARGMAX_EN
    n_checks++; if (o_idx !== 2'd1) $display("FAIL basic_idx actual=%0d required=1", o_idx); else n_pass++;
`endif
    idle(1);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL basic_pulse actual=%b required=0", o_valid); else n_pass++;
    n_checks++; if (o !== 32'd9) $display("FAIL basic_hold actual=%h required=%h", o, 32'd9); else n_pass++;
  endtask

  task automatic test_masking;
    send(32'd10, 32'hFFFFFFF0, 32'h12345678);
    send(32'd20, 32'hFFFFFFF0, 32'hDEADBEEF);
    send(32'd15, 32'hFFFFFFF0, 32'h0BADF00D);
    send(32'd1,  32'hFFFFFFF0, 32'h80000000);
    idle(1);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL mask_valid actual=%b required=1", o_valid); else n_pass++;
    n_checks++; if (o !== 32'h80000014) $display("FAIL mask_o actual=%h required=%h", o, 32'h80000014); else n_pass++;
  endtask

  task automatic test_gaps;
    int seen;
    seen = 0;
    send(32'd5, $urandom, $urandom); send(32'd9, $urandom, $urandom);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (o_valid) seen++;
    end
    send(32'd3, $urandom, $urandom);
    if (o_valid) seen++;
    send(32'd7, $urandom, 32'd0);
    if (o_valid) seen++;
    n_checks++; if (seen !== 0) $display("FAIL gap_quiet actual=%0d required=0", seen); else n_pass++;
    idle(1);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL gap_valid actual=%b required=1", o_valid); else n_pass++;
    n_checks++; if (o !== 32'd9) $display("FAIL gap_o actual=%h required=%h", o, 32'd9); else n_pass++;
    idle(1);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL gap_pulse actual=%b required=0", o_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals[8];
    int seen;
    vals = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd6, 32'd7, 32'd5};
    seen = 0;
    for (int i = 0; i < 4; i++) send(vals[i], 32'd0, 32'd0);
    send(vals[4], 32'd0, 32'd0);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL b2b_valid1 actual=%b required=1", o_valid); else n_pass++;
    n_checks++; if (o !== 32'd4) $display("FAIL b2b_o1 actual=%h required=%h", o, 32'd4); else n_pass++;
    for (int i = 5; i < 8; i++) begin
      send(vals[i], 32'd0, 32'd0);
      if (o_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL b2b_spacing actual=%0d required=0", seen); else n_pass++;
    idle(1);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL b2b_valid2 actual=%b required=1", o_valid); else n_pass++;
    n_checks++; if (o !== 32'd8) $display("FAIL b2b_o2 actual=%h required=%h", o, 32'd8); else n_pass++;
  endtask

  task automatic test_ties;
    send(32'hFFFFFFFF, $urandom, $urandom); send(32'hFFFFFFFF, $urandom, $urandom);
    send(32'd0, $urandom, $urandom);        send(32'd0, $urandom, 32'd0);
    idle(1);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL tie_valid actual=%b required=1", o_valid); else n_pass++;
    n_checks++; if (o !== 32'hFFFFFFFF) $display("FAIL tie_o actual=%h required=%h", o, 32'hFFFFFFFF); else n_pass++;
`ifdef MAXPOOL_ARGMAX_EN
    n_checks++; if (o_idx !== 2'd0) $display("FAIL tie_idx actual=%0d required=0", o_idx); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    send(32'd100, $urandom, $urandom); send(32'd200, $urandom, $urandom);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (o !== 32'd0) $display("FAIL rstmid_o actual=%h required=0", o); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL rstmid_valid actual=%b required=0", o_valid); else n_pass++;
    n_checks++; if (dut.cnt_r !== 2'd0) $display("FAIL rstmid_cnt actual=%0d required=0", dut.cnt_r); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    send(32'd1, $urandom, $urandom); if (o_valid) seen++;
    send(32'd1, $urandom, $urandom); if (o_valid) seen++;
    send(32'd1, $urandom, $urandom); if (o_valid) seen++;
    send(32'd2, $urandom, 32'd0);    if (o_valid) seen++;
    n_checks++; if (seen !== 0) $display("FAIL rstmid_aborted actual=%0d required=0", seen); else n_pass++;
    idle(1);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL rstmid_valid2 actual=%b required=1", o_valid); else n_pass++;
    n_checks++; if (o !== 32'd2) $display("FAIL rstmid_o2 actual=%h required=%h", o, 32'd2); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] vals[4];
    logic [31:0] rout, eo;
    int eidx, seen;
    for (int w = 0; w < 30; w++) begin
      seen = 0;
      for (int i = 0; i < 4; i++)
        vals[i] = (w % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rout = $urandom;
      ref_pool(vals, rout, eo, eidx);
      for (int i = 0; i < 4; i++) begin
        send(vals[i], $urandom, (i == 3) ? rout : $urandom);
        if (i > 0 && o_valid) seen++;
        if (i < 3 && $urandom_range(0, 2) == 0) begin
          idle($urandom_range(1, 3));
          if (o_valid) seen++;
        end
      end
      idle(1);
      n_checks++; if (seen !== 0) $display("FAIL rand_quiet w=%0d actual=%0d required=0", w, seen); else n_pass++;
      n_checks++; if (o_valid !== 1'b1) $display("FAIL rand_valid w=%0d actual=%b required=1", w, o_valid); else n_pass++;
      n_checks++; if (o !== eo) $display("FAIL rand_o w=%0d actual=%h required=%h", w, o, eo); else n_pass++;
`ifdef MAXPOOL_ARGMAX_EN
      n_checks++; if (o_idx !== 2'(eidx)) $display("FAIL rand_idx w=%0d actual=%0d required=%0d", w, o_idx, eidx); else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_masking;
    test_gaps;
    test_back_to_back;
    test_ties;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
